// File: rtl/coin_acceptor.sv
// Coin-mech front end: sync, debounce and classify $5/$10 coins.
// Emits one-cycle coin codes, drives the reject gate, latches jams.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 8,
  parameter int JAM_CYCLES      = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sense_5,
  input  logic       sense_10,
  output logic [1:0] coin,
  output logic       reject_gate,
  output logic       jam,
  output logic [7:0] count_5,
  output logic [7:0] count_10
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int JW = $clog2(JAM_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_REJECT,
    S_GAP,
    S_JAM
  } state_t;

  // Bit 0 is the $5 line, bit 1 the $10 line.
  logic [1:0]         s1_q;
  logic [1:0]         s2_q;
  logic [1:0]         filt_q;
  logic [1:0]         filt_d;
  logic [1:0]         prev_q;
  logic [1:0][DW-1:0] db_q;
  logic [1:0][DW-1:0] db_d;

  state_t      state_q;
  logic        type_q;
  logic [JW-1:0] jcnt_q;
  logic [GW-1:0] gcnt_q;
  logic [1:0]  coin_q;
  logic        rej_q;
  logic        jam_q;
  logic [7:0]  cnt5_q;
  logic [7:0]  cnt10_q;

  logic [1:0] rise;
  logic [1:0] fall;
  logic       quiet;

  always_comb begin
    filt_d = filt_q;
    db_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (db_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = ~filt_q[i];
        end else begin
          db_d[i] = db_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      prev_q <= '0;
      db_q   <= '0;
    end else begin
      s1_q   <= {sense_10, sense_5};
      s2_q   <= s1_q;
      filt_q <= filt_d;
      prev_q <= filt_q;
      db_q   <= db_d;
    end
  end

  assign rise = filt_q & ~prev_q;
  assign fall = ~filt_q & prev_q;
  // A coin still settling in the debouncer keeps the gap window open.
  assign quiet = ~|{s2_q, filt_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      type_q  <= 1'b0;
      jcnt_q  <= '0;
      gcnt_q  <= '0;
      coin_q  <= 2'b00;
      rej_q   <= 1'b0;
      jam_q   <= 1'b0;
      cnt5_q  <= '0;
      cnt10_q <= '0;
    end else begin
      coin_q <= 2'b00;
      unique case (state_q)
        S_IDLE: begin
          if (rise == 2'b11 || (|rise && !enable)) begin
            state_q <= S_REJECT;
            rej_q   <= 1'b1;
            jcnt_q  <= '0;
          end else if (|rise) begin
            state_q <= S_HOLD;
            type_q  <= rise[1];
            jcnt_q  <= '0;
          end
        end
        S_HOLD: begin
          if (rise[!type_q]) begin
            state_q <= S_REJECT;
            rej_q   <= 1'b1;
            jcnt_q  <= '0;
          end else if (fall[type_q]) begin
            state_q <= S_GAP;
            gcnt_q  <= '0;
            if (type_q) begin
              coin_q <= 2'b10;
              if (cnt10_q != 8'hFF) cnt10_q <= cnt10_q + 8'd1;
            end else begin
              coin_q <= 2'b01;
              if (cnt5_q != 8'hFF) cnt5_q <= cnt5_q + 8'd1;
            end
          end else if (jcnt_q == JW'(JAM_CYCLES - 1)) begin
            state_q <= S_JAM;
            jam_q   <= 1'b1;
          end else begin
            jcnt_q <= jcnt_q + 1'b1;
          end
        end
        S_REJECT: begin
          if (filt_q == 2'b00) begin
            state_q <= S_GAP;
            rej_q   <= 1'b0;
            gcnt_q  <= '0;
          end else if (jcnt_q == JW'(JAM_CYCLES - 1)) begin
            state_q <= S_JAM;
            rej_q   <= 1'b0;
            jam_q   <= 1'b1;
          end else begin
            jcnt_q <= jcnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (|rise) begin
            state_q <= S_REJECT;
            rej_q   <= 1'b1;
            jcnt_q  <= '0;
          end else if (!quiet) begin
            gcnt_q <= '0;
          end else if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        S_JAM: begin
          jam_q <= 1'b1;
          rej_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign coin        = coin_q;
  assign reject_gate = rej_q;
  assign jam         = jam_q;
  assign count_5     = cnt5_q;
  assign count_10    = cnt10_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with short debounce/gap/jam windows.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sense_5;
  logic       sense_10;
  logic [1:0] coin;
  logic       reject_gate;
  logic       jam;
  logic [7:0] count_5;
  logic [7:0] count_10;

  int tests = 0;
  int fails = 0;
  int p5 = 0;
  int p10 = 0;
  int p11 = 0;
  int rej_cyc = 0;
  int last_code = 0;

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES(8),
    .JAM_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sense_5(sense_5),
    .sense_10(sense_10),
    .coin(coin),
    .reject_gate(reject_gate),
    .jam(jam),
    .count_5(count_5),
    .count_10(count_10)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (coin == 2'b01) p5 = p5 + 1;
      if (coin == 2'b10) p10 = p10 + 1;
      if (coin == 2'b11) p11 = p11 + 1;
      if (coin != 2'b00) last_code = int'(coin);
      if (reject_gate) rej_cyc = rej_cyc + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests = tests + 1;
    if (got != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int  s5, s10, r0;
  bit  found;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    sense_5  = 1'b0;
    sense_10 = 1'b0;
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_coin", int'(coin), 0);
    check("rst_reject", int'(reject_gate), 0);
    check("rst_jam", int'(jam), 0);
    check("rst_cnt5", int'(count_5), 0);
    check("rst_cnt10", int'(count_10), 0);
    cyc(1);

    // Clean $5: pulse lands 7 clocks after the raw fall
    enable  = 1'b1;
    sense_5 = 1'b1;
    cyc(20);
    sense_5 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("clean5_pre", int'(coin), 0);
    @(negedge clk);
    check("clean5_pulse", int'(coin), 1);
    @(negedge clk);
    check("clean5_post", int'(coin), 0);
    cyc(15);
    check("clean5_cnt", int'(count_5), 1);
    check("clean5_npulse", p5, 1);
    check("clean5_norej", rej_cyc, 0);

    // Bounce on $10, then a settled coin
    for (int i = 0; i < 3; i++) begin
      sense_10 = 1'b1;
      cyc(2);
      sense_10 = 1'b0;
      cyc(2);
    end
    cyc(8);
    check("bounce_nopulse", p10, 0);
    sense_10 = 1'b1;
    cyc(20);
    sense_10 = 1'b0;
    cyc(20);
    check("bounce_npulse", p10, 1);
    check("bounce_cnt10", int'(count_10), 1);
    check("bounce_code", last_code, 2);
    check("bounce_norej", rej_cyc, 0);

    // Disabled insertion
    enable  = 1'b0;
    sense_5 = 1'b1;
    cyc(12);
    check("dis_gate_on", int'(reject_gate), 1);
    cyc(8);
    sense_5 = 1'b0;
    cyc(10);
    check("dis_gate_off", int'(reject_gate), 0);
    cyc(12);
    check("dis_npulse", p5, 1);
    check("dis_cnt5", int'(count_5), 1);
    enable = 1'b1;

    // Both lines together
    r0       = rej_cyc;
    sense_5  = 1'b1;
    sense_10 = 1'b1;
    cyc(12);
    check("both_gate_on", int'(reject_gate), 1);
    cyc(8);
    sense_5  = 1'b0;
    sense_10 = 1'b0;
    cyc(22);
    check("both_gate_off", int'(reject_gate), 0);
    check("both_rej_seen", int'(rej_cyc > r0), 1);
    check("both_np5", p5, 1);
    check("both_np10", p10, 1);
    check("both_cnt5", int'(count_5), 1);
    check("both_cnt10", int'(count_10), 1);

    // Gap violation after an accepted $10
    sense_10 = 1'b1;
    cyc(10);
    sense_10 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (coin == 2'b10) found = 1'b1;
    end
    check("gap_acc_pulse", int'(found), 1);
    repeat (3) @(posedge clk);
    #1;
    sense_5 = 1'b1;
    cyc(12);
    check("gap_gate_on", int'(reject_gate), 1);
    sense_5 = 1'b0;
    cyc(25);
    check("gap_gate_off", int'(reject_gate), 0);
    check("gap_cnt5", int'(count_5), 1);
    check("gap_cnt10", int'(count_10), 2);
    sense_5 = 1'b1;
    cyc(10);
    sense_5 = 1'b0;
    cyc(12);
    check("gap_new_cnt5", int'(count_5), 2);
    check("gap_new_code", last_code, 1);

    // Jam, then reset
    s10      = p10;
    sense_10 = 1'b1;
    cyc(100);
    check("jam_set", int'(jam), 1);
    check("jam_nopulse", p10 - s10, 0);
    sense_10 = 1'b0;
    cyc(20);
    check("jam_held", int'(jam), 1);
    check("jam_gate", int'(reject_gate), 0);
    check("jam_nopulse2", p10 - s10, 0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("jrst_jam", int'(jam), 0);
    check("jrst_cnt5", int'(count_5), 0);
    check("jrst_cnt10", int'(count_10), 0);
    check("jrst_coin", int'(coin), 0);
    cyc(1);

    // Saturation of count_5
    s5 = p5;
    r0 = rej_cyc;
    for (int i = 0; i < 260; i++) begin
      sense_5 = 1'b1;
      cyc(6);
      sense_5 = 1'b0;
      cyc(16);
      if (i == 254) check("sat_at255", int'(count_5), 255);
    end
    check("sat_cnt5", int'(count_5), 255);
    check("sat_npulse", p5 - s5, 260);
    check("sat_norej", rej_cyc - r0, 0);
    check("sat_cnt10", int'(count_10), 0);
    check("never_11", p11, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage between the raw coin-mech sensors and the vending FSM.
- Synchronises and debounces the two optical lines, classifies each coin as $5 or $10, and emits the FSM coin code (00 none, 01 $5, 10 $10) as a single-cycle pulse.
- Drives the reject gate for illegal or disabled insertions, latches jams, and keeps saturating audit counts.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronised cycles a line must hold a new level before its filtered level changes
GAP_CYCLES, 8, minimum idle cycles after a coin event before the next detection is legal
JAM_CYCLES, 1024, maximum cycles a filtered line may stay high before a jam is declared

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  vending FSM ready to accept credit
sense_5  in  1  raw asynchronous $5 sensor, high while a coin occludes it
sense_10  in  1  raw asynchronous $10 sensor
coin  out  2  coin code to vending FSM: 00 none, 01 $5, 10 $10; never 11
reject_gate  out  1  reject solenoid drive
jam  out  1  jam flag, latched until reset
count_5  out  8  accepted $5 coins, saturating
count_10  out  8  accepted $10 coins, saturating

Behaviour:
- Reset: coin=00, reject_gate=0, jam=0, counts=0, synchroniser flops=0, filtered levels=0, all counters=0, state=IDLE. Reset mid-coin abandons the coin with no credit.
- A raw line high across reset release is debounced as a fresh rise.
- Sync: two flops per line.
- Debounce, per line: the counter increments each cycle the synchronised level differs from the filtered level and clears when they match. On reaching DEBOUNCE_CYCLES the filtered level toggles and the counter clears. Counter width is clog2(DEBOUNCE_CYCLES+1).
- Latency: the FSM acts on a filtered edge on the edge after it changes. Raw change to registered FSM action is DEBOUNCE_CYCLES+3 clocks.
- IDLE:
  - exactly one filtered rise with enable=1 -> HOLD, latch type, clear jam counter;
  - one rise with enable=0 -> REJECT;
  - both rise on the same cycle -> REJECT.
- HOLD:
  - latched line falls -> emit code for exactly one cycle, increment matching count (saturate at 255), go to GAP;
  - other line rises -> REJECT, no credit;
  - jam counter reaches JAM_CYCLES -> JAM;
  - enable dropping during HOLD does not cancel the credit.
- REJECT: reject_gate=1 while in state; exits to GAP once both filtered lines are low. No code emitted, no counts. Jam counter also runs here; on reaching JAM_CYCLES -> JAM.
- GAP: counts GAP_CYCLES cycles with both lines low, then -> IDLE. Any filtered rise during GAP -> REJECT, and the gap count restarts on re-entry.
- JAM: jam=1, coin=00, reject_gate=0, sensors ignored; exit only via reset.
- coin is registered, is 00 in every cycle without an accept event, and has at most one non-zero cycle per physical coin. A coin pulse and a REJECT entry never occur on the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, GAP_CYCLES=8, JAM_CYCLES=64):
- Clean $5: enable=1; sense_5 high 20 cycles then low. Expect coin=01 for exactly one cycle, 7 clocks after the raw fall; count_5=1; reject_gate stays 0.
- Bounce filtering: sense_10 toggles every 2 cycles for 12 cycles, settles high 20 cycles, then low. Expect exactly one coin=10 pulse, count_10=1, no pulses during bounce.
- Disabled or illegal insertion:
  - enable=0, insert $5 -> reject_gate high from HOLD-equivalent detection until filtered low, coin stays 00, count_5 unchanged;
  - sense_5 and sense_10 rise together -> same reject behaviour.
- Gap violation: accept a $10; raise sense_5 3 cycles after the coin pulse -> REJECT, reject_gate=1, no credit; after both lines low plus 8 idle cycles, a new $5 is accepted with coin=01.
- Jam and reset: hold sense_10 high 100 cycles -> jam=1, coin never pulses. Release the line -> jam stays 1. Assert reset 1 cycle -> jam=0, counts=0, coin=00.
- Saturation: accept 260 $5 coins -> count_5=255 and holds; coin still pulses 01 for each accepted coin.
